// File: rtl/pcap_replay_pkg.sv
// Shared types and constants for the pcap replay pacer: FSM encoding, delay width,
// default delay field position, and the delay-to-release-threshold helper.
package pcap_replay_pkg;

  localparam int DELAY_W           = 32;
  localparam int DEFAULT_DELAY_LSB = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PASS = 2'd2,
    S_DROP = 2'd3
  } pacer_state_t;

  // The WAIT->PASS decision is registered, so release one count early to land the
  // handshake exactly D cycles after the previous first beat; 0 behaves like 1.
  function automatic logic [DELAY_W-1:0] delay_threshold(input logic [DELAY_W-1:0] d);
    return (d == '0) ? '0 : d - DELAY_W'(1);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream register slice: one output register plus one skid register,
// 1-cycle latency, full throughput, outputs stable under backpressure, sync clear.
module axis_skid_buffer #(
  parameter int DATA_W = 256,
  parameter int STRB_W = 32,
  parameter int USER_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [STRB_W-1:0] s_tstrb,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [STRB_W-1:0] m_tstrb,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  localparam int W = DATA_W + STRB_W + USER_W + 1;

  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic [W-1:0] s_beat;
  logic         main_vld;
  logic         skid_vld;

  assign s_beat   = {s_tdata, s_tstrb, s_tuser, s_tlast};
  assign s_tready = !skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (clr) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || m_tready) begin
      // Output register is free this cycle; drain the skid entry first to keep order.
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= s_tvalid;
        if (s_tvalid) main_q <= s_beat;
      end
    end else if (s_tvalid && s_tready) begin
      skid_q   <= s_beat;
      skid_vld <= 1'b1;
    end
  end

  assign {m_tdata, m_tstrb, m_tuser, m_tlast} = main_q;
  assign m_tvalid = main_vld;

endmodule

// File: rtl/pcap_replay_pacer.sv
// Paces replayed pcap packets by the per-packet inter-packet delay carried in tuser.
// Optional statistics counters are built when PCAP_REPLAY_PACER_STATS_EN is defined.
//
// state | meaning
// IDLE  | no packet in progress; latch delay when a first beat is offered
// WAIT  | first beat held until pace_en=0 or elapsed reaches the delay
// PASS  | forward beats through the skid buffer until tlast
// DROP  | soft reset hit mid-packet; swallow beats until tlast
module pcap_replay_pacer
  import pcap_replay_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DELAY_LSB        = DEFAULT_DELAY_LSB
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic                            sw_rst,
  input  logic                            pace_en,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
`ifdef PCAP_REPLAY_PACER_STATS_EN
  ,
  output logic [31:0]                     pkt_cnt,
  output logic [31:0]                     late_cnt
`endif
);

  pacer_state_t        state_q, state_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [DELAY_W-1:0]  elapsed_q;
  logic [DELAY_W-1:0]  delay_in;
  logic                first_pend_q, first_pend_d;
  logic                skid_in_ready;
  logic                skid_in_valid;
  logic                pass_hs;
  logic                release_ok;

  assign delay_in      = s_axis_tuser[C_DELAY_LSB +: DELAY_W];
  assign skid_in_valid = (state_q == S_PASS) && s_axis_tvalid;
  assign pass_hs       = skid_in_valid && skid_in_ready;
  assign release_ok    = !pace_en || (elapsed_q >= delay_q);

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      S_PASS:  s_axis_tready = skid_in_ready;
      S_DROP:  s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= S_IDLE;
      delay_q      <= '0;
      first_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      first_pend_q <= first_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    first_pend_d = first_pend_q;
    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid && !sw_rst) begin
          delay_d = delay_threshold(delay_in);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sw_rst) begin
          state_d = S_IDLE;
        end else if (release_ok) begin
          state_d      = S_PASS;
          first_pend_d = 1'b1;
        end
      end
      S_PASS: begin
        if (pass_hs) first_pend_d = 1'b0;
        // Mid-packet means a beat already left (or is leaving now) and tlast has not.
        if (sw_rst) begin
          state_d = (pass_hs ? !s_axis_tlast : !first_pend_q) ? S_DROP : S_IDLE;
        end else if (pass_hs && s_axis_tlast) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      elapsed_q <= '1;
    end else if (sw_rst) begin
      elapsed_q <= '1;
    end else if (pass_hs && first_pend_q) begin
      elapsed_q <= DELAY_W'(1);
    end else if (elapsed_q != '1) begin
      elapsed_q <= elapsed_q + DELAY_W'(1);
    end
  end

  axis_skid_buffer #(
    .DATA_W (C_AXIS_DATA_WIDTH),
    .STRB_W (C_AXIS_DATA_WIDTH/8),
    .USER_W (C_AXIS_TUSER_WIDTH)
  ) u_skid (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .clr      (sw_rst),
    .s_tdata  (s_axis_tdata),
    .s_tstrb  (s_axis_tstrb),
    .s_tuser  (s_axis_tuser),
    .s_tvalid (skid_in_valid),
    .s_tlast  (s_axis_tlast),
    .s_tready (skid_in_ready),
    .m_tdata  (m_axis_tdata),
    .m_tstrb  (m_axis_tstrb),
    .m_tuser  (m_axis_tuser),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tready (m_axis_tready)
  );

`ifdef PCAP_REPLAY_PACER_STATS_EN
  logic late_evt;
  assign late_evt = (state_q == S_IDLE) && s_axis_tvalid && !sw_rst && pace_en &&
                    (elapsed_q > delay_in);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_cnt  <= '0;
      late_cnt <= '0;
    end else if (sw_rst) begin
      pkt_cnt  <= '0;
      late_cnt <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
      if (late_evt) late_cnt <= late_cnt + 32'd1;
    end
  end
`endif

endmodule
